// File: rtl/clock_step_controller.sv
// clock_step_controller
// Run/halt/single-step pacer for the single-cycle RISC-V core. Every state
// update in the core is gated by core_ce, which this block issues as a
// one-cycle pulse once per div_reg cycles in RUN, or once per button press
// in STEP mode. It also keeps a retired-enable counter with an optional
// auto-halt breakpoint, and a divided tick for LED/debug display.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   run_req    level, request RUN
//   halt_req   level, request HALT (wins over everything else)
//   step_req   level, debounced button; rising edge requests one step
//   div_wr     write strobe for the divide ratio
//   div_wdata  new divide ratio (0 is treated as 1)
//   brk_en     enable auto-halt when the enable count reaches brk_val
//   brk_val    enable-count value at which to auto-halt
//   core_ce    one-cycle enable to the core, decoded from registers only
//   tick_out   toggles on every core_ce
//   ce_count   number of core_ce pulses issued (wraps)
//   state      00 = HALT, 01 = RUN, 10 = STEP

module clock_step_controller #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int CNT_W       = 32,
   parameter int START_RUN   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             div_wr,
   input  logic [DIV_W-1:0] div_wdata,
   input  logic             brk_en,
   input  logic [CNT_W-1:0] brk_val,
   output logic             core_ce,
   output logic             tick_out,
   output logic [CNT_W-1:0] ce_count,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_HALT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_STEP = 2'b10;

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_last;
   logic             step_prev;
   logic             step_edge;
   logic             brk_hit;

   // div_reg is never 0, so div_last never underflows
   assign div_last  = div_reg - DIV_W'(1);
   assign step_edge = step_req & ~step_prev;

   // Enable is decoded purely from registered state so the core never sees
   // a combinational path from the buttons or the host interface.
   assign core_ce = (state == ST_STEP) || ((state == ST_RUN) && (cnt == div_last));

   // Breakpoint fires on the enable that will bring ce_count up to brk_val;
   // that enable is still issued and counted, then the FSM parks in HALT.
   assign brk_hit = brk_en && core_ce && ((ce_count + CNT_W'(1)) == brk_val);

   // Main sequential block: FSM, divide counter, step edge detector,
   // enable counter and display tick. A divide-ratio write is applied last
   // so it overrides whatever the FSM wanted to do with cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (START_RUN != 0) ? ST_RUN : ST_HALT;
         div_reg   <= DIV_W'(DEFAULT_DIV);
         cnt       <= '0;
         step_prev <= 1'b0;
         tick_out  <= 1'b0;
         ce_count  <= '0;
      end else begin
         step_prev <= step_req;

         if (core_ce) begin
            ce_count <= ce_count + CNT_W'(1);
            tick_out <= ~tick_out;
         end

         case (state)
            ST_HALT: begin
               cnt <= '0;
               if (halt_req) begin
                  state <= ST_HALT;
               end else if (run_req) begin
                  state <= ST_RUN;
               end else if (step_edge) begin
                  state <= ST_STEP;
               end
            end
            ST_RUN: begin
               if (halt_req || brk_hit) begin
                  state <= ST_HALT;
                  cnt   <= '0;
               end else if (cnt == div_last) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_STEP: begin
               state <= ST_HALT;
               cnt   <= '0;
            end
            default: begin
               state <= ST_HALT;
               cnt   <= '0;
            end
         endcase

         if (div_wr) begin
            div_reg <= (div_wdata == '0) ? DIV_W'(1) : div_wdata;
            cnt     <= '0;
         end
      end
   end

endmodule

// File: doc/clock_step_controller.md
# clock_step_controller

Run/halt/single-step controller that paces the RISC-V core by issuing a one-cycle clock-enable pulse (`core_ce`) at a programmable divide ratio. It sits between the board clock and the single-cycle core and drives every state-update enable in the core. It also provides a 50%-duty divided tick for LED/debug display, a retired-enable counter, and an optional auto-halt breakpoint on that counter.

## Interface
- `DIV_W`, 16: width of the divide-ratio register.
- `DEFAULT_DIV`, 2: divide ratio loaded at reset (must be ≥1).
- `CNT_W`, 32: width of the enable counter and breakpoint value.
- `START_RUN`, 0: reset state; 0 = HALT, 1 = RUN.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run_req`  in  1  level; request RUN.
- `halt_req`  in  1  level; request HALT.
- `step_req`  in  1  level (debounced button); a rising edge requests one step.
- `div_wr`  in  1  write strobe for the divide ratio.
- `div_wdata`  in  DIV_W  new divide ratio.
- `brk_en`  in  1  enable auto-halt on the count match.
- `brk_val`  in  CNT_W  enable-count value at which to auto-halt.
- `core_ce`  out  1  one-cycle enable to the core.
- `tick_out`  out  1  toggles on every `core_ce`.
- `ce_count`  out  CNT_W  number of `core_ce` pulses issued.
- `state`  out  2  00 = HALT, 01 = RUN, 10 = STEP.

## Operation
- Registers:
  - `state`
  - `div_reg`
  - `cnt` (DIV_W bits, 0..div_reg-1)
  - `step_prev` (sampled `step_req`)
  - `tick_out`
  - `ce_count`
- `core_ce` decode:
  - `core_ce = (state==STEP) | (state==RUN & cnt==div_reg-1)`.
  - It is decoded from registers only; there is no combinational path from any input.
- Step edge: `step_edge = step_req & ~step_prev`. `step_prev` updates every cycle.
- FSM transitions, evaluated each edge, highest priority first:
  - HALT:
    - `halt_req` → HALT.
    - `run_req` → RUN, with `cnt` set to 0.
    - `step_edge` → STEP.
    - Otherwise stay in HALT.
  - RUN:
    - `halt_req` → HALT.
    - `brk_en & core_ce & (ce_count+1 == brk_val)` → HALT.
    - Otherwise stay in RUN.
    - `step_edge` is ignored.
  - STEP: always → HALT after exactly one cycle. All requests are ignored in STEP.
- Counter:
  - In RUN: `cnt` increments, and wraps to 0 when `cnt==div_reg-1`.
  - In HALT and STEP: `cnt` is held at 0.
- Divide write:
  - `div_wr` in any state: `div_reg <= (div_wdata==0) ? 1 : div_wdata` and `cnt <= 0`.
  - A `core_ce` decoded in the same cycle is still issued.
  - The write overrides the normal `cnt` update.
- `ce_count` increments by 1 on every cycle with `core_ce=1` and wraps at 2^CNT_W.
- `tick_out` inverts on every cycle with `core_ce=1`.
- With `div_reg = 1` in RUN, `core_ce` is high continuously.
- Halt taking effect on a `core_ce` cycle: that enable is issued and counted. No enable is issued after it.

## Timing
- Reset values:
  - `state` = HALT (or RUN if `START_RUN`)
  - `div_reg = DEFAULT_DIV`
  - `cnt = 0`
  - `step_prev = 0`
  - `core_ce = 0` (RUN: first pulse after `DEFAULT_DIV` cycles)
  - `tick_out = 0`
  - `ce_count = 0`
- `rst` overrides all other inputs, including in mid-RUN and mid-STEP; no `core_ce` is issued in the cycle after reset.
- RUN entry:
  - `run_req` sampled at edge k → state = RUN from edge k.
  - First `core_ce` is in the cycle after edge k+div_reg-1.
  - Subsequent pulses are every `div_reg` cycles.
- Step:
  - `step_req` rises and is sampled at edge k → `core_ce` is high for exactly the cycle after edge k.
  - Back to HALT at edge k+1.
  - Holding `step_req` high gives no further steps until it falls and rises again.
- Halt: `halt_req` at edge k → `core_ce` is 0 from edge k onward.
- `tick_out` period is 2·div_reg cycles in RUN.

## Test plan
- Reset with `START_RUN=0`, `DEFAULT_DIV=2`, `run_req` pulsed → `core_ce` high every 2nd cycle; after 10 cycles `ce_count=5` and `tick_out` has toggled 5 times.
- HALT, `step_req` held high for 5 cycles, then low 2 cycles, then high again → exactly two `core_ce` pulses, `state` sequence HALT→STEP→HALT twice, `ce_count=2`.
- RUN at div 4, `div_wr` with `div_wdata=3` on the cycle `cnt==3` → that `core_ce` still issued; next pulse 3 cycles later and every 3 thereafter. Then `div_wdata=0` → `div_reg=1`, `core_ce` continuous.
- RUN at div 2, `brk_en=1`, `brk_val=4` → HALT after the 4th pulse; `ce_count=4`, no further `core_ce`. A subsequent `run_req` resumes; `ce_count=5` on the next pulse with no re-break.
- `halt_req`, `run_req` and a step edge all in the same HALT cycle → stays HALT. `run_req` and step edge together → RUN.
- `rst` asserted mid-RUN on a `core_ce` cycle → next cycle all outputs at reset values and `div_reg` back to `DEFAULT_DIV`.
